// File: rtl/vga_scan.sv
// 640x480@60 VGA timing generator with a tick-aligned colour sampling stage.
// Optional macro VGA_SCAN_TRANSPARENT_EN: colour word 16'hFFFF is shown as black.
module vga_scan #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] icolor,
    output logic [9:0]  posX,
    output logic [8:0]  posY,
    output logic        pix_tick,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // One pipeline slot per pixel: frame-origin flag, visibility and raw syncs.
    typedef struct packed {
        logic first;
        logic vis;
        logic hs;
        logic vs;
    } tap_t;

    localparam tap_t TAP_IDLE = 4'b0011;

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt, v_cnt;
    logic [9:0]    h_nxt, v_nxt;
    logic          vis, vis_nxt;
    tap_t          head, tail_in;
    tap_t          pipe_q [PIPE_LAT];
    logic [11:0]   color;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pix_tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    assign vis     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

    // Coordinates are built from the next counter values so they move with the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            posX  <= '0;
            posY  <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            posX  <= vis_nxt ? h_nxt : 10'd0;
            posY  <= vis_nxt ? v_nxt[8:0] : 9'd0;
        end
    end

    always_comb begin
        head       = TAP_IDLE;
        head.first = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        head.vis   = vis;
        head.hs    = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        head.vs    = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= TAP_IDLE;
        end else if (pix_tick) begin
            pipe_q[0] <= head;
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // tail_in is the slot that reaches the outputs at the coming tick.
    generate
        if (PIPE_LAT == 1) begin : g_tap_direct
            assign tail_in = head;
        end else begin : g_tap_pipe
            assign tail_in = pipe_q[PIPE_LAT-2];
        end
    endgenerate

    assign de = pipe_q[PIPE_LAT-1].vis;
    assign hs = pipe_q[PIPE_LAT-1].hs;
    assign vs = pipe_q[PIPE_LAT-1].vs;

`ifdef VGA_SCAN_TRANSPARENT_EN
    assign color = (icolor == 16'hFFFF) ? 12'h000 : icolor[11:0];
`else
    logic unused_hi;
    assign unused_hi = ^icolor[15:12];
    assign color     = icolor[11:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && tail_in.first;
            if (pix_tick) begin
                {r, g, b} <= tail_in.vis ? color : 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan on a shrunken raster: a pixel-arithmetic model
// predicts every clock's outputs, a negedge monitor compares them.
module tb_vga_scan;

    localparam int CLK_DIV = 4;
    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 10, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;
    localparam int MAX_ERRORS = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] icolor = 16'h0000;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic        pix_tick, hs, vs, de, frame_start;
    logic [3:0]  r, g, b;

    vga_scan #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .icolor(icolor), .posX(posX), .posY(posY),
        .pix_tick(pix_tick), .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
        .frame_start(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [15:0] tab [VA][HA];
    logic [35:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          rst_gen = 0;

    function automatic logic [11:0] shade(input logic [15:0] w);
`ifdef VGA_SCAN_TRANSPARENT_EN
        if (w == 16'hFFFF) return 12'h000;
`endif
        return w[11:0];
    endfunction

    // Expected outputs after the e-th clock edge since reset release.
    function automatic logic [35:0] predict(input int e);
        int ticks, p, x, y, qx, qy;
        logic tick_e, hs_e, vs_e, de_e, fs_e;
        logic [11:0] rgb_e;
        logic [9:0] px;
        logic [8:0] py;
        ticks  = e / CLK_DIV;
        tick_e = (e % CLK_DIV) == CLK_DIV - 1;
        hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0; fs_e = 1'b0; rgb_e = 12'h000;
        if (ticks > 0) begin
            p = ticks - 1;
            x = p % HT;
            y = (p / HT) % VT;
            de_e  = (x < HA) && (y < VA);
            hs_e  = !((x >= HA + HF) && (x < HA + HF + HSW));
            vs_e  = !((y >= VA + VF) && (y < VA + VF + VSW));
            rgb_e = de_e ? shade(tab[y][x]) : 12'h000;
            fs_e  = (e % CLK_DIV == 0) && (x == 0) && (y == 0);
        end
        qx = ticks % HT;
        qy = (ticks / HT) % VT;
        px = 10'd0;
        py = 9'd0;
        if (qx < HA && qy < VA) begin
            px = 10'(qx);
            py = 9'(qy);
        end
        return {tick_e, hs_e, vs_e, de_e, rgb_e, fs_e, px, py};
    endfunction

    // driver tasks
    task automatic fill_pattern();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                tab[y][x] = {4'h0, 4'(x), 4'(y), 4'hA};
    endtask

    task automatic fill_random();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                tab[y][x] = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
        // Blanking presents (0,0) to the lookup; a bright word there must not leak out.
        tab[0][0] = 16'h0FFF;
    endtask

    task automatic finish_report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Colour lookup stand-in: answers half a clock after the coordinate moves.
    initial begin
        int xi, yi;
        forever begin
            @(negedge clk);
            xi = int'(posX);
            yi = int'(posY);
            icolor = (xi < HA && yi < VA) ? tab[yi][xi] : 16'hDEAD;
        end
    end

    // Reference model: one expectation per clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            edge_n  = 0;
            rst_gen = rst_gen + 1;
        end else begin
            edge_n = edge_n + 1;
        end
        exp_q.push_back(predict(edge_n));
    end

    // Monitor: per-clock compare plus frame-level accounting.
    int seen_gen = 0;
    int clk_idx = 0;
    int last_fs = 0;
    int de_clks = 0;
    bit fs_valid = 1'b0;

    always @(negedge clk) begin
        logic [35:0] exp_v, act_v;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pix_tick, hs, vs, de, r, g, b, frame_start, posX, posY};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL scan_out t=%0t got %h want %h (tick,hs,vs,de,rgb,fs,x,y)",
                         $time, act_v, exp_v);
            end
        end
        if (seen_gen != rst_gen) begin
            seen_gen = rst_gen;
            fs_valid = 1'b0;
            de_clks  = 0;
        end
        clk_idx = clk_idx + 1;
        if (frame_start) begin
            if (fs_valid) begin
                checks = checks + 1;
                if (clk_idx - last_fs != FRAME_CLKS) begin
                    errors = errors + 1;
                    $display("FAIL frame_period got %0d want %0d", clk_idx - last_fs, FRAME_CLKS);
                end
                checks = checks + 1;
                if (de_clks != HA * VA * CLK_DIV) begin
                    errors = errors + 1;
                    $display("FAIL de_count got %0d want %0d", de_clks, HA * VA * CLK_DIV);
                end
            end
            fs_valid = 1'b1;
            last_fs  = clk_idx;
            de_clks  = 0;
        end
        if (de) de_clks = de_clks + 1;
        if (errors >= MAX_ERRORS) finish_report();
    end

    // Stimulus sequence
    initial begin
        fill_pattern();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Run one frame, then stop at line 5 pixel 10 of the next and pulse reset.
        repeat (FRAME_CLKS + (5 * HT + 10) * CLK_DIV) @(negedge clk);
        rst_n = 1'b0;
        fill_random();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME_CLKS + 300) @(negedge clk);
        finish_report();
    end

endmodule
